// File: rtl/x_vector_line_cache.sv
// Direct-mapped x-vector line cache for an SpMV PE: looks up column indices, issues one
// memory read per missing word and returns x-values strictly in column order.
module x_vector_line_cache #(
  parameter int NUM_LINES         = 4,
  parameter int LINE_WORDS        = 8,
  parameter int DATA_WIDTH        = 64,
  parameter int ADDR_WIDTH        = 48,
  parameter int ORDER_FIFO_DEPTH  = 1024,
  parameter int RSP_FIFO_DEPTH    = 512,
  parameter int ALMOST_FULL_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           col,
  input  logic                  push_col,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic                  flush,
  output logic                  req_mem,
  output logic [ADDR_WIDTH-1:0] req_mem_addr,
  input  logic                  rsp_mem_push,
  input  logic [DATA_WIDTH-1:0] rsp_mem_q,
  output logic                  push_x,
  output logic [DATA_WIDTH-1:0] x_val,
  input  logic                  stall,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int LW_BITS        = $clog2(LINE_WORDS);
  localparam int LOG2_NUM_LINES = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 0;
  localparam int IDX_W          = (LOG2_NUM_LINES > 0) ? LOG2_NUM_LINES : 1;
  localparam int TAG_W          = 32 - LW_BITS - LOG2_NUM_LINES;
  localparam int ENT_W          = LW_BITS + IDX_W + 1;
  localparam int WADDR_W        = IDX_W + LW_BITS;
  localparam int OPTR_W         = $clog2(ORDER_FIFO_DEPTH);
  localparam int OCNT_W         = $clog2(ORDER_FIFO_DEPTH + 1);
  localparam int RPTR_W         = $clog2(RSP_FIFO_DEPTH);
  localparam int RCNT_W         = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int IFL_W          = $clog2(ORDER_FIFO_DEPTH + RSP_FIFO_DEPTH + 1);
  localparam int BYTES          = DATA_WIDTH / 8;

  localparam logic [OCNT_W-1:0] ORD_FULL = OCNT_W'(ORDER_FIFO_DEPTH);
  localparam logic [OCNT_W-1:0] ORD_AF   = OCNT_W'(ORDER_FIFO_DEPTH - ALMOST_FULL_COUNT);
  localparam logic [OPTR_W-1:0] ORD_LAST = OPTR_W'(ORDER_FIFO_DEPTH - 1);
  localparam logic [RCNT_W-1:0] RSP_FULL = RCNT_W'(RSP_FIFO_DEPTH);
  localparam logic [RPTR_W-1:0] RSP_LAST = RPTR_W'(RSP_FIFO_DEPTH - 1);
  localparam logic [IFL_W-1:0]  IFL_AF   = IFL_W'(RSP_FIFO_DEPTH - ALMOST_FULL_COUNT);

  function automatic logic [LW_BITS-1:0] col_off(input logic [31:0] c);
    return c[LW_BITS-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] col_idx(input logic [31:0] c);
    logic [31:0] s;
    s = c >> LW_BITS;
    return (LOG2_NUM_LINES == 0) ? '0 : s[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] col_tag(input logic [31:0] c);
    logic [31:0] s;
    s = c >> (LW_BITS + LOG2_NUM_LINES);
    return s[TAG_W-1:0];
  endfunction

  function automatic logic [LINE_WORDS-1:0] one_hot(input logic [LW_BITS-1:0] o);
    return LINE_WORDS'(1) << o;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Address wraps modulo 2^ADDR_WIDTH by truncation.
  function automatic logic [ADDR_WIDTH-1:0] col_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [31:0] c);
    return base + ADDR_WIDTH'(c) * ADDR_WIDTH'(BYTES);
  endfunction

  logic                  vld_p0;
  logic [31:0]           col_p0;
  logic                  vld_p1;
  logic                  hit_p1;
  logic [31:0]           col_p1;

  logic [LINE_WORDS-1:0] line_vld  [NUM_LINES];
  logic [TAG_W-1:0]      line_tag  [NUM_LINES];
  logic [DATA_WIDTH-1:0] line_data [NUM_LINES*LINE_WORDS];

  logic [IDX_W-1:0]      lk_idx;
  logic [LW_BITS-1:0]    lk_off;
  logic [TAG_W-1:0]      lk_tag;
  logic                  tag_match;
  logic                  lk_hit;

  logic [ENT_W-1:0]      ord_mem [ORDER_FIFO_DEPTH];
  logic [OPTR_W-1:0]     ord_wr_ptr, ord_rd_ptr;
  logic [OCNT_W-1:0]     ord_cnt;
  logic                  ord_full, ord_wr, ord_pop, miss_issue;

  logic [DATA_WIDTH-1:0] rsp_mem [RSP_FIFO_DEPTH];
  logic [RPTR_W-1:0]     rsp_wr_ptr, rsp_rd_ptr;
  logic [RCNT_W-1:0]     rsp_cnt;
  logic                  rsp_wr, rsp_pop;

  logic [ENT_W-1:0]      ord_head;
  logic                  head_hit;
  logic [IDX_W-1:0]      head_idx;
  logic [LW_BITS-1:0]    head_off;
  logic [WADDR_W-1:0]    head_waddr;
  logic [DATA_WIDTH-1:0] rsp_head;

  logic                  out_vld_p1;
  logic [DATA_WIDTH-1:0] out_data_p1;
  logic [IFL_W-1:0]      in_flight;

  // ---- S0: register incoming column ----
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= push_col;
    col_p0 <= col;
  end

  // ---- S1: tag/valid lookup and same-edge line update ----
  always_comb begin
    lk_idx    = col_idx(col_p0);
    lk_off    = col_off(col_p0);
    lk_tag    = col_tag(col_p0);
    tag_match = (line_tag[lk_idx] == lk_tag);
    lk_hit    = tag_match & line_vld[lk_idx][lk_off];
  end

  // Flush wins over the same-cycle miss update so the line stays invalid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_LINES; i++) line_vld[i] <= '0;
    end else if (vld_p0 && !lk_hit) begin
      if (tag_match) line_vld[lk_idx][lk_off] <= 1'b1;
      else           line_vld[lk_idx]         <= one_hot(lk_off);
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0 && !tag_match) line_tag[lk_idx] <= lk_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
    hit_p1 <= lk_hit;
    col_p1 <= col_p0;
  end

  // ---- S2: order FIFO push, memory request, counters ----
  assign ord_full   = (ord_cnt == ORD_FULL);
  assign ord_wr     = vld_p1 & ~ord_full;
  assign miss_issue = ord_wr & ~hit_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_mem      <= 1'b0;
      req_mem_addr <= '0;
      overflow     <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      req_mem <= miss_issue;
      if (miss_issue)          req_mem_addr <= col_addr(start_address, col_p1);
      if (vld_p1 && ord_full)  overflow     <= 1'b1;
      if (ord_wr && hit_p1)    hit_count    <= sat_inc(hit_count);
      if (miss_issue)          miss_count   <= sat_inc(miss_count);
    end
  end

  always_ff @(posedge clk) begin
    if (ord_wr) ord_mem[ord_wr_ptr] <= {col_off(col_p1), col_idx(col_p1), hit_p1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ord_wr_ptr <= '0;
      ord_rd_ptr <= '0;
      ord_cnt    <= '0;
    end else begin
      if (ord_wr)  ord_wr_ptr <= (ord_wr_ptr == ORD_LAST) ? '0 : ord_wr_ptr + 1'b1;
      if (ord_pop) ord_rd_ptr <= (ord_rd_ptr == ORD_LAST) ? '0 : ord_rd_ptr + 1'b1;
      case ({ord_wr, ord_pop})
        2'b10:   ord_cnt <= ord_cnt + 1'b1;
        2'b01:   ord_cnt <= ord_cnt - 1'b1;
        default: ord_cnt <= ord_cnt;
      endcase
    end
  end

  // Response FIFO: memory returns data in request order.
  assign rsp_wr = rsp_mem_push & (rsp_cnt != RSP_FULL);

  always_ff @(posedge clk) begin
    if (rsp_wr) rsp_mem[rsp_wr_ptr] <= rsp_mem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_cnt    <= '0;
    end else begin
      if (rsp_wr)  rsp_wr_ptr <= (rsp_wr_ptr == RSP_LAST) ? '0 : rsp_wr_ptr + 1'b1;
      if (rsp_pop) rsp_rd_ptr <= (rsp_rd_ptr == RSP_LAST) ? '0 : rsp_rd_ptr + 1'b1;
      case ({rsp_wr, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
        2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // ---- P0: in-order pop decision ----
  always_comb begin
    ord_head   = ord_mem[ord_rd_ptr];
    head_hit   = ord_head[0];
    head_idx   = ord_head[IDX_W:1];
    head_off   = ord_head[ENT_W-1:IDX_W+1];
    head_waddr = {head_idx, head_off};
    rsp_head   = rsp_mem[rsp_rd_ptr];
    ord_pop    = ~stall & (ord_cnt != '0) & (head_hit | (rsp_cnt != '0));
    rsp_pop    = ord_pop & ~head_hit;
  end

  // ---- P1: line write on miss, hit read or miss bypass ----
  always_ff @(posedge clk) begin
    if (rsp_pop) line_data[head_waddr] <= rsp_head;
    out_data_p1 <= head_hit ? line_data[head_waddr] : rsp_head;
  end

  always_ff @(posedge clk) begin
    if (rst) out_vld_p1 <= 1'b0;
    else     out_vld_p1 <= ord_pop;
  end

  // ---- P2: registered x-value output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      push_x <= 1'b0;
      x_val  <= '0;
    end else begin
      push_x <= out_vld_p1;
      if (out_vld_p1) x_val <= out_data_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight   <= '0;
      almost_full <= 1'b0;
    end else begin
      case ({miss_issue, rsp_pop})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
      almost_full <= (in_flight > IFL_AF) | (ord_cnt > ORD_AF);
    end
  end

endmodule

// File: tb/tb_x_vector_line_cache.sv
// Scoreboard bench for x_vector_line_cache: directed column streams with an in-order
// memory model; expected x-values and request addresses are queued at issue time.
module tb_x_vector_line_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] col = '0;
  logic        push_col = 1'b0;
  logic [47:0] start_address = 48'h1000;
  logic        flush = 1'b0;
  logic        req_mem;
  logic [47:0] req_mem_addr;
  logic        rsp_mem_push = 1'b0;
  logic [63:0] rsp_mem_q = '0;
  logic        push_x;
  logic [63:0] x_val;
  logic        stall = 1'b0;
  logic        almost_full;
  logic        overflow;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  x_vector_line_cache dut (
    .clk(clk), .rst(rst), .col(col), .push_col(push_col), .start_address(start_address),
    .flush(flush), .req_mem(req_mem), .req_mem_addr(req_mem_addr),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_q(rsp_mem_q), .push_x(push_x), .x_val(x_val),
    .stall(stall), .almost_full(almost_full), .overflow(overflow),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  localparam logic [47:0] BASE = 48'h1000;

  int tests = 0;
  int fails = 0;
  int push_seen = 0;
  bit mem_en = 1'b1;
  bit sb_on = 1'b1;
  logic [63:0] exp_x[$];
  logic [47:0] exp_req[$];
  logic [47:0] mq[$];

  function automatic logic [47:0] addr_of(input int c);
    return BASE + 48'(c) * 48'd8;
  endfunction

  function automatic logic [63:0] xdata(input logic [47:0] a);
    return {16'hD00D, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares every output strobe against the head of its expectation queue.
  always @(negedge clk) begin
    if (push_x) push_seen++;
    if (sb_on && push_x) begin
      if (exp_x.size() == 0) begin
        tests++; fails++;
        $display("FAIL x_unexpected: actual=%0h required=none", x_val);
      end else check("x_val", x_val, exp_x.pop_front());
    end
    if (sb_on && req_mem) begin
      if (exp_req.size() == 0) begin
        tests++; fails++;
        $display("FAIL req_unexpected: actual=%0h required=none", req_mem_addr);
      end else check("req_addr", 64'(req_mem_addr), 64'(exp_req.pop_front()));
    end
  end

  // Memory model: in-order responses, data derived from the request address.
  always @(negedge clk) begin
    if (req_mem) mq.push_back(req_mem_addr);
    if (mem_en && mq.size() > 0) begin
      rsp_mem_push = 1'b1;
      rsp_mem_q    = xdata(mq.pop_front());
    end else begin
      rsp_mem_push = 1'b0;
    end
  end

  task automatic issue(input int c, input bit miss, input bit want_x);
    @(negedge clk);
    col = 32'(c);
    push_col = 1'b1;
    if (want_x) exp_x.push_back(xdata(addr_of(c)));
    if (miss) exp_req.push_back(addr_of(c));
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    push_col = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_x.size() != 0 || exp_req.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_x.size() + exp_req.size()), 64'd0);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    push_col = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_mem"},      64'(req_mem),      64'd0);
    check({tag, "_req_mem_addr"}, 64'(req_mem_addr), 64'd0);
    check({tag, "_push_x"},       64'(push_x),       64'd0);
    check({tag, "_x_val"},        x_val,             64'd0);
    check({tag, "_almost_full"},  64'(almost_full),  64'd0);
    check({tag, "_overflow"},     64'(overflow),     64'd0);
    check({tag, "_hit_count"},    64'(hit_count),    64'd0);
    check({tag, "_miss_count"},   64'(miss_count),   64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    push_col = 1'b0;
    sb_on = 1'b0;
    mem_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic resume_after_reset();
    exp_x.delete();
    exp_req.delete();
    mq.delete();
    sb_on = 1'b1;
    mem_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    idle(2);

    // Cold run: every word misses.
    for (int c = 0; c < 8; c++) issue(c, 1'b1, 1'b1);
    idle(1);
    drain("cold_drain");
    check("cold_miss_count", 64'(miss_count), 64'd8);
    check("cold_hit_count",  64'(hit_count),  64'd0);

    // Repeated hits on word 3.
    for (int k = 0; k < 3; k++) issue(3, 1'b0, 1'b1);
    idle(1);
    drain("hit_drain");
    check("hit_hit_count",  64'(hit_count),  64'd3);
    check("hit_miss_count", 64'(miss_count), 64'd8);

    // Conflict: col 5 and 37 share line 0 with different tags.
    pulse_flush();
    issue(5, 1'b1, 1'b1);
    issue(37, 1'b1, 1'b1);
    issue(5, 1'b1, 1'b1);
    idle(1);
    drain("conflict_drain");
    check("conflict_miss_count", 64'(miss_count), 64'd11);

    // Stall: fill line 1, then queue 4 hits and hold stall.
    for (int c = 8; c < 12; c++) issue(c, 1'b1, 1'b1);
    idle(1);
    drain("stall_fill_drain");
    for (int c = 8; c < 12; c++) issue(c, 1'b0, 1'b1);
    @(negedge clk);
    push_col = 1'b0;
    stall = 1'b1;
    repeat (3) @(negedge clk);
    ps = push_seen;
    repeat (17) @(negedge clk);
    check("stall_hold", 64'(push_seen - ps), 64'd0);
    check("stall_pending", 64'(exp_x.size() > 0), 64'd1);
    stall = 1'b0;
    drain("stall_resume_drain");
    check("stall_hit_count", 64'(hit_count), 64'd7);

    // Flush between two lookups of col 2: the second re-requests, a third hits.
    issue(2, 1'b1, 1'b1);
    idle(1);
    drain("flush_first_drain");
    pulse_flush();
    issue(2, 1'b1, 1'b1);
    idle(1);
    drain("flush_second_drain");
    issue(2, 1'b0, 1'b1);
    idle(1);
    drain("flush_third_drain");
    check("flush_miss_count", 64'(miss_count), 64'd17);
    check("flush_hit_count",  64'(hit_count),  64'd8);

    // Reset mid-stream: outputs return to reset values, nothing emerges afterwards.
    for (int c = 16; c < 24; c++) issue(c, 1'b1, 1'b1);
    do_reset();
    check_reset_outputs("midrst");
    resume_after_reset();
    ps = push_seen;
    idle(12);
    check("midrst_quiet", 64'(push_seen - ps), 64'd0);

    // Back-pressure thresholds with memory withheld.
    mem_en = 1'b0;
    for (int c = 0; c < 496; c++) issue(c, 1'b1, 1'b0);
    idle(6);
    check("af_at_496", 64'(almost_full), 64'd0);
    issue(496, 1'b1, 1'b0);
    idle(6);
    check("af_at_497", 64'(almost_full), 64'd1);
    for (int c = 497; c < 1024; c++) issue(c, 1'b1, 1'b0);
    idle(6);
    check("ovf_at_full", 64'(overflow), 64'd0);
    issue(1024, 1'b0, 1'b0);
    idle(6);
    check("ovf_after_drop", 64'(overflow), 64'd1);
    check("ovf_miss_count", 64'(miss_count), 64'd1024);
    drain("ovf_req_drain");
    do_reset();
    check_reset_outputs("final_rst");
    resume_after_reset();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
